cgra_operand_mux: RTL and testbench

//  Parametrised NUM_IN:1 operand selector for CGRA PE inputs, with a registered valid/ready output.
//  A select token (sel + sel_valid) chooses one input channel. The selected beat is consumed and

---
 rtl/cgra_operand_mux.sv | 123 ++++++++++++
 tb/tb_cgra_operand_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cgra_operand_mux.sv
// NUM_IN:1 operand selector for CGRA PE inputs. A select token picks one channel; the consumed
// beat goes through a 2-entry skid buffer (main + skid register) to a valid/ready output.
module cgra_operand_mux #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sticky
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_data, skid_data, sel_data;
    logic             main_err, skid_err;
    logic             sel_hit, sel_in_valid;
    logic             acc, drn;
    logic             load_main, load_skid, main_from_skid;

    // sel_hit clear means sel is out of range; sel_data then stays zero, which is the error beat.
    always_comb begin
        sel_hit      = 1'b0;
        sel_in_valid = 1'b0;
        sel_data     = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_hit      = 1'b1;
                sel_in_valid = in_valid[i];
                sel_data     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ready = !rst && (state != TWO);
    assign acc       = sel_valid && sel_ready && (!sel_hit || sel_in_valid);
    assign out_valid = (state != EMPTY);
    assign drn       = out_valid && out_ready;
    assign out_data  = main_data;
    assign out_err   = main_err;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_ready[i] = acc && (sel == SEL_W'(i));
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (acc && !drn) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (acc && drn) begin
                    load_main = 1'b1;
                end else if (drn) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (drn) begin
                    state_nxt      = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= sel_data;
                main_err  <= !sel_hit;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_err  <= !sel_hit;
            end
            if (acc && !sel_hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cgra_operand_mux.sv
// Bench for cgra_operand_mux: directed scenarios plus random traffic on a 4-input and a 3-input
// instance, checked against a queue-based model of the buffered beats.
module tb_cgra_operand_mux;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ch [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [1:0]   sel;
    logic         sel_valid;
    logic         out_ready;

    logic [3:0]   ir4;
    logic         sr4, oe4, ov4, es4;
    logic [31:0]  od4;
    logic [2:0]   ir3;
    logic         sr3, oe3, ov3, es3;
    logic [31:0]  od3;

    always #5 clk = ~clk;
    assign in_data = {ch[3], ch[2], ch[1], ch[0]};

    cgra_operand_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir4),
        .sel(sel), .sel_valid(sel_valid), .sel_ready(sr4), .out_data(od4), .out_err(oe4),
        .out_valid(ov4), .out_ready(out_ready), .err_sticky(es4)
    );

    cgra_operand_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_ready(ir3),
        .sel(sel), .sel_valid(sel_valid), .sel_ready(sr3), .out_data(od3), .out_err(oe3),
        .out_valid(ov3), .out_ready(out_ready), .err_sticky(es3)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    bit    cur;      // 0: check the 4-input instance, 1: the 3-input instance
    beat_t q[$];     // beats accepted but not yet drained, oldest first
    bit    sticky;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sel_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        q.delete();
        sticky = 1'b0;
        rst    = 1'b0;
    endtask

    // Compare every output with the model just before the edge, then advance the model.
    task automatic cycle();
        int       n;
        bit       oor, e_acc, e_sr, e_ov, drained;
        logic [3:0] e_ir;
        beat_t    b;
        #1;
        n     = cur ? 3 : 4;
        oor   = (int'(sel) >= n);
        e_sr  = !rst && (q.size() < 2);
        e_acc = sel_valid && e_sr && (oor || in_valid[sel]);
        e_ir  = (e_acc && !oor) ? 4'(1 << sel) : 4'b0;
        e_ov  = (q.size() > 0);
        chk("sel_ready", 32'(cur ? sr3 : sr4), 32'(e_sr));
        chk("in_ready", 32'(cur ? {1'b0, ir3} : ir4), 32'(e_ir));
        chk("out_valid", 32'(cur ? ov3 : ov4), 32'(e_ov));
        if (e_ov) begin
            chk("out_data", cur ? od3 : od4, q[0].d);
            chk("out_err", 32'(cur ? oe3 : oe4), 32'(q[0].e));
        end
        chk("err_sticky", 32'(cur ? es3 : es4), 32'(sticky));
        b.d     = oor ? 32'd0 : ch[sel];
        b.e     = oor;
        drained = e_ov && out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            sticky = 1'b0;
        end else begin
            if (drained) void'(q.pop_front());
            if (e_acc) q.push_back(b);
            if (e_acc && oor) sticky = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        cur       = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'h0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) ch[i] = 32'd0;
        do_reset();
        chk("rst_out_valid", 32'(ov4), 32'd0);
        chk("rst_out_data", od4, 32'd0);
        chk("rst_out_err", 32'(oe4), 32'd0);
        chk("rst_err_sticky", 32'(es4), 32'd0);

        // single beat, one-cycle latency
        ch[0] = 32'd84; in_valid = 4'hf; out_ready = 1'b1; sel = 2'd0; sel_valid = 1'b1;
        cycle();
        sel_valid = 1'b0;
        chk("t1_valid", 32'(ov4), 32'd1);
        chk("t1_data", od4, 32'd84);
        cycle();

        // back-to-back tokens at full throughput
        ch[1] = 32'd132; ch[2] = 32'd28; ch[0] = 32'd158; sel_valid = 1'b1;
        sel = 2'd1; cycle();
        sel = 2'd2; cycle();
        chk("t2_data_b", od4, 32'd28);
        sel = 2'd0; cycle();
        sel_valid = 1'b0;
        chk("t2_data_c", od4, 32'd158);
        cycle(); cycle();

        // back-pressure fills the skid, then drains in order
        out_ready = 1'b0; ch[1] = 32'd12; ch[2] = 32'd147; sel_valid = 1'b1;
        sel = 2'd1; cycle();
        sel = 2'd2; cycle();
        sel = 2'd0; cycle();
        chk("t3_full_ready", 32'(sr4), 32'd0);
        chk("t3_held", od4, 32'd12);
        sel_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("t3_second", od4, 32'd147);
        chk("t3_ready_back", 32'(sr4), 32'd1);
        cycle(); cycle();

        // selected channel not valid holds the token off
        sel = 2'd3; sel_valid = 1'b1; in_valid = 4'b0111; ch[3] = 32'd36;
        repeat (3) cycle();
        chk("t4_no_beat", 32'(ov4), 32'd0);
        in_valid = 4'hf;
        cycle();
        sel_valid = 1'b0;
        chk("t4_data", od4, 32'd36);
        cycle();
        chk("t4_single", 32'(ov4), 32'd0);

        // out-of-range select on the 3-input instance
        do_reset();
        cur = 1'b1;
        sel = 2'd3; sel_valid = 1'b1; out_ready = 1'b1;
        cycle();
        sel_valid = 1'b0;
        chk("t5_data", od3, 32'd0);
        chk("t5_err", 32'(oe3), 32'd1);
        chk("t5_sticky", 32'(es3), 32'd1);
        cycle(); cycle();
        chk("t5_sticky_held", 32'(es3), 32'd1);
        out_ready = 1'b0; sel_valid = 1'b1;
        sel = 2'd3; cycle();
        ch[1] = 32'd5; sel = 2'd1; cycle();
        sel_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // reset while full discards both beats and clears sticky
        out_ready = 1'b0; sel_valid = 1'b1;
        ch[0] = 32'd39; sel = 2'd0; cycle();
        ch[1] = 32'd471; sel = 2'd1; cycle();
        sel_valid = 1'b0;
        chk("t6_full", 32'(sr3), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0; out_ready = 1'b1;
        chk("t6_valid", 32'(ov3), 32'd0);
        chk("t6_sticky", 32'(es3), 32'd0);
        cycle(); cycle();

        // random traffic on both instances
        for (int k = 0; k < 2; k++) begin
            do_reset();
            cur = (k == 1);
            for (int i = 0; i < 400; i++) begin
                for (int c = 0; c < 4; c++) ch[c] = $urandom;
                sel       = 2'($urandom_range(0, 3));
                sel_valid = ($urandom % 4) != 0;
                in_valid  = 4'($urandom);
                out_ready = ($urandom % 3) != 0;
                rst       = ($urandom % 60) == 0;
                cycle();
            end
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
